mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single fixed-latency memory bus of the discrete-gate CPU between the
//   instruction-fetch port (I) and the load/store port (D). Uses round-robin grant
//   and a wait-state counter. Each access is held stable on the bus, then answered
//   with a one-cycle registered ack carrying read data.
//   Sits between the core front end / LSU and the board memory interface.
// PARAMETERS
//   AW           32  address width
//   DW           32  data width (multiple of 8); BE width = DW/8
//   WAIT_STATES  2   extra bus cycles per access (0 legal); bus held WAIT_STATES+1 cycles
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   i_req      in   1      fetch request; held with i_addr until i_ack
//   i_addr     in   AW     fetch address
//   i_ack      out  1      one-cycle pulse: fetch done, i_rdata valid
//   i_rdata    out  DW     fetch data (shared register with d_rdata)
//   d_req      in   1      load/store request; held with d_* until d_ack
//   d_we       in   1      1 = store
//   d_addr     in   AW     data address
//   d_wdata    in   DW     store data
//   d_be       in   DW/8   byte enables for stores
//   d_ack      out  1      one-cycle pulse: access done, d_rdata valid on loads
//   d_rdata    out  DW     load data
//   mem_en     out  1      bus cycle active
//   mem_we     out  1      bus write strobe
//   mem_addr   out  AW     bus address
//   mem_wdata  out  DW     bus write data
//   mem_be     out  DW/8   bus byte enables
//   mem_rdata  in   DW     bus read data, valid on the last ACCESS cycle
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset values
//   - All outputs are 0.
//   - State is IDLE, wait counter is 0, last_grant = I (D wins the first tie).
//   - All outputs are registered.
//   FSM
//   - IDLE:
//     - No request: stay in IDLE.
//     - One request: grant it.
//     - Both requesting: grant the port not in last_grant.
//     - On grant: latch addr, wdata, we, be into the bus registers; load cnt = WAIT_STATES;
//       update last_grant; go to ACCESS.
//     - I grant drives we = 0 and be = all ones.
//   - ACCESS:
//     - mem_en = 1; mem_* held constant.
//     - If cnt != 0: cnt decrements.
//     - If cnt == 0: capture mem_rdata into rdata (loads and fetches; unchanged on stores);
//       go to RESP.
//   - RESP:
//     - mem_en = 0 and mem_we = 0; addr, wdata and be hold their last value.
//     - The granted port's ack = 1 for exactly this cycle.
//     - Always go to IDLE next.
//   Timing
//   - Request sampled in IDLE at cycle t: mem_en is high for cycles t+1 .. t+1+WAIT_STATES;
//     ack is at t+2+WAIT_STATES.
//   - Back-to-back: a request reasserted or held in the cycle after ack is granted at that
//     IDLE cycle. The period is WAIT_STATES+3 cycles per access.
//   - Both ports continuously requesting: grants alternate D, I, D, I, ...
//   Boundary conditions
//   - req is ignored outside IDLE.
//   - Dropping req before ack is a protocol violation: the access still completes and acks.
//   - A new request in the same cycle as ack is not seen until the following IDLE cycle.
//   - i_ack and d_ack are never high together; at most one access is outstanding.
//   - rst_n low mid-access: all outputs clear immediately, no ack is issued, requesters
//     must reissue. A store may be partially performed by memory.
//   - Counter width is max(1, clog2(WAIT_STATES+1)).
// TESTING
//   - Reset: rst_n=0 mid-ACCESS -> mem_en, acks and busy are 0 asynchronously; after release
//     the first tie grants D.
//   - Single fetch (WAIT_STATES=2): i_req at t0, i_addr=0x100, mem_rdata=0xDEADBEEF
//     -> mem_en high t1..t3 with mem_addr=0x100, mem_be=0xF, mem_we=0;
//     i_ack at t4 with i_rdata=0xDEADBEEF.
//   - Store: d_we=1, d_addr=0x2004, d_wdata=0x11223344, d_be=0x3
//     -> mem_we=1 and mem_be=0x3 for 3 cycles; d_ack at t4; d_rdata unchanged.
//   - Contention: i_req and d_req held constantly -> grant order D, I, D, I with a
//     5-cycle ack spacing; never both acks high.
//   - WAIT_STATES=0 build -> mem_en for 1 cycle; ack 2 cycles after the request.
//   - Request on the ack cycle: d_req asserted the cycle i_ack is high -> D is granted in
//     the next IDLE cycle; mem_en rises 2 cycles after i_ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory bus between fetch (I) and load/store (D) ports.
// Latency: grant in IDLE, WAIT_STATES+1 bus cycles, registered ack one cycle later; requests wait while busy.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int BW = DW / 8;
  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          last_d;   // last grant went to D, so I wins the next tie
  logic          cur_d;    // owner of the access in flight
  logic          grant_i;
  logic          grant_d;
  logic [DW-1:0] rdata;

  assign i_rdata = rdata;
  assign d_rdata = rdata;

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || !last_d)) begin
          grant_d   = 1'b1;
          state_nxt = ACCESS;
        end else if (i_req) begin
          grant_i   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      last_d    <= 1'b0;
      cur_d     <= 1'b0;
      rdata     <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      busy      <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      busy  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            mem_en <= 1'b1;
            cnt    <= CW'(WAIT_STATES);
            last_d <= grant_d;
            cur_d  <= grant_d;
            if (grant_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_be    <= d_be;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= i_addr;
              mem_be   <= {BW{1'b1}};
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Last bus cycle: read data is valid now; stores leave rdata alone.
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_we) rdata <= mem_rdata;
            if (cur_d) d_ack <= 1'b1;
            else       i_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req, i_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_be, mem_be;

  logic        z_i_req, z_i_ack, z_d_req, z_d_we, z_d_ack, z_mem_en, z_mem_we, z_busy;
  logic [31:0] z_i_addr, z_i_rdata, z_d_addr, z_d_wdata, z_d_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;
  logic [3:0]  z_d_be, z_mem_be;

  int checks = 0;
  int passed = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n),
    .i_req(z_i_req), .i_addr(z_i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata), .d_be(z_d_be),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_be(z_mem_be), .mem_rdata(z_mem_rdata), .busy(z_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [138:0] outs;
    rst_n = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
    z_i_req = 0; z_i_addr = 0; z_d_req = 0; z_d_we = 0; z_d_addr = 0; z_d_wdata = 0; z_d_be = 0;
    z_mem_rdata = 0;
    #12;
    outs = {i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_be, busy};
    checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h required 0", outs);
    else passed++;
    outs = {z_i_ack, z_i_rdata, z_d_ack, z_d_rdata, z_mem_en, z_mem_we, z_mem_addr, z_mem_be, z_busy};
    checks++;
    if (outs !== '0 || z_mem_wdata !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_outputs_ws0: got %h required 0", outs);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    i_req = 1'b1; i_addr = 32'h40;
    tick();
    checks++;
    if ({mem_en, busy, mem_addr} !== {1'b1, 1'b1, 32'h40})
      $display("FAIL reset_pre_access: got %b%b %h required 11 00000040", mem_en, busy, mem_addr);
    else passed++;
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, i_ack, d_ack, busy, mem_addr} !== '0)
      $display("FAIL reset_async_clear: en=%b iack=%b dack=%b busy=%b addr=%h required all 0",
               mem_en, i_ack, d_ack, busy, mem_addr);
    else passed++;
    tick();
    rst_n = 1'b1;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    tick();
    checks++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h80})
      $display("FAIL reset_first_tie_d: en=%b we=%b addr=%h required 1 0 00000080", mem_en, mem_we, mem_addr);
    else passed++;
    tick(); tick(); tick();
    checks++;
    if ({d_ack, i_ack} !== 2'b10) $display("FAIL reset_tie_ack: d/i ack=%b required 10", {d_ack, i_ack});
    else passed++;
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h100; mem_rdata = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) mem_rdata = 32'hDEADBEEF;
      checks++;
      if ({mem_en, mem_we, mem_be, mem_addr, busy} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b1})
        $display("FAIL fetch_bus_c%0d: en=%b we=%b be=%h addr=%h busy=%b required 1 0 f 00000100 1",
                 c, mem_en, mem_we, mem_be, mem_addr, busy);
      else passed++;
    end
    tick();
    checks++;
    if ({i_ack, d_ack, mem_en, i_rdata} !== {3'b100, 32'hDEADBEEF})
      $display("FAIL fetch_ack: iack=%b dack=%b en=%b rdata=%h required 1 0 0 deadbeef",
               i_ack, d_ack, mem_en, i_rdata);
    else passed++;
    i_req = 1'b0; mem_rdata = 32'h0;
    tick();
    checks++;
    if ({i_ack, busy, mem_en} !== 3'b000)
      $display("FAIL fetch_idle: iack=%b busy=%b en=%b required 000", i_ack, busy, mem_en);
    else passed++;
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'h11223344; d_be = 4'h3;
    mem_rdata = 32'h55555555;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'h3, 32'h2004, 32'h11223344})
        $display("FAIL store_bus_c%0d: en=%b we=%b be=%h addr=%h wdata=%h required 1 1 3 00002004 11223344",
                 c, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
      else passed++;
    end
    tick();
    checks++;
    if ({d_ack, i_ack, mem_en, mem_we, d_rdata} !== {4'b1000, 32'hDEADBEEF})
      $display("FAIL store_ack: dack=%b iack=%b en=%b we=%b rdata=%h required 1 0 0 0 deadbeef",
               d_ack, i_ack, mem_en, mem_we, d_rdata);
    else passed++;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    tick();
  endtask

  task automatic test_contention();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_rdata = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      logic [1:0] exp_ack;
      tick();
      exp_ack = {(c == 9 || c == 19), (c == 4 || c == 14)};
      checks++;
      if ({i_ack, d_ack} !== exp_ack)
        $display("FAIL contention_ack_c%0d: i/d ack=%b required %b", c, {i_ack, d_ack}, exp_ack);
      else passed++;
      if (c == 1 || c == 11 || c == 6 || c == 16) begin
        checks++;
        if (mem_addr !== ((c == 1 || c == 11) ? 32'h400 : 32'h300))
          $display("FAIL contention_grant_c%0d: addr=%h required %h", c, mem_addr,
                   (c == 1 || c == 11) ? 32'h400 : 32'h300);
        else passed++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_ack_cycle();
    i_req = 1'b1; i_addr = 32'h500;
    tick(); tick(); tick(); tick();
    checks++;
    if ({i_ack, d_ack} !== 2'b10) $display("FAIL ackcyc_iack: i/d ack=%b required 10", {i_ack, d_ack});
    else passed++;
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    tick();
    checks++;
    if ({mem_en, i_ack} !== 2'b00) $display("FAIL ackcyc_idle: en=%b iack=%b required 00", mem_en, i_ack);
    else passed++;
    tick();
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 32'h600})
      $display("FAIL ackcyc_grant_d: en=%b addr=%h required 1 00000600", mem_en, mem_addr);
    else passed++;
    tick(); tick(); tick();
    checks++;
    if ({d_ack, i_ack} !== 2'b10) $display("FAIL ackcyc_dack: d/i ack=%b required 10", {d_ack, i_ack});
    else passed++;
    d_req = 1'b0;
    tick();
  endtask

  task automatic test_drop_req();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; mem_rdata = 32'hCAFEF00D;
    tick();
    d_req = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hCAFEF00D})
      $display("FAIL drop_req_ack: dack=%b rdata=%h required 1 cafef00d", d_ack, d_rdata);
    else passed++;
    tick();
    checks++;
    if ({d_ack, busy} !== 2'b00) $display("FAIL drop_req_idle: dack=%b busy=%b required 00", d_ack, busy);
    else passed++;
  endtask

  task automatic test_ws0();
    z_i_req = 1'b1; z_i_addr = 32'h10; z_mem_rdata = 32'h12345678;
    tick();
    checks++;
    if ({z_mem_en, z_mem_addr, z_i_ack} !== {1'b1, 32'h10, 1'b0})
      $display("FAIL ws0_access: en=%b addr=%h iack=%b required 1 00000010 0", z_mem_en, z_mem_addr, z_i_ack);
    else passed++;
    tick();
    checks++;
    if ({z_i_ack, z_mem_en, z_i_rdata} !== {2'b10, 32'h12345678})
      $display("FAIL ws0_ack: iack=%b en=%b rdata=%h required 1 0 12345678", z_i_ack, z_mem_en, z_i_rdata);
    else passed++;
    z_i_req = 1'b0;
    tick();
    checks++;
    if ({z_i_ack, z_busy} !== 2'b00) $display("FAIL ws0_idle: iack=%b busy=%b required 00", z_i_ack, z_busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_ack_cycle();
    test_drop_req();
    test_ws0();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
